// File: rtl/player_status_if.sv
// Status link between the game control side and the UART status transmitter.
// master drives the game status and observes the line; slave is the transmitter.
interface player_status_if;
  logic       start_pressed;
  logic       game_ended;
  logic [7:0] score;
  logic       tx;
  logic       tx_busy;
  logic       frame_sent;

  modport master (
    output start_pressed, game_ended, score,
    input  tx, tx_busy, frame_sent
  );

  modport slave (
    input  start_pressed, game_ended, score,
    output tx, tx_busy, frame_sent
  );
endinterface

// File: rtl/player_status_tx.sv
// Sends {A,ended,start}, score, xor as a 3-byte 8N1 frame on change or keep-alive.
// Latency: input change to start bit is 2 cycles when idle; no backpressure, changes queue one frame.
module player_status_tx #(
  parameter int CLK_HZ         = 65_000_000,
  parameter int BAUD           = 115_200,
  parameter int REFRESH_CYCLES = 6_500_000
) (
  input logic            clk,
  input logic            rst,
  player_status_if.slave link
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int RW  = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_idx;
  logic [RW-1:0]   refresh_cnt;
  logic            pending;
  logic            prev_start, prev_ended;
  logic [7:0]      prev_score;
  logic [7:0]      b0, b1;
  logic [7:0]      cur_byte;
  logic            baud_end, frame_start, change, refresh_hit;
  logic            tx_o, busy_o, sent_o;

  always_comb begin
    baud_end    = (baud_cnt == DW'(DIV - 1));
    frame_start = (state == IDLE) && pending;
    change      = (prev_start != link.start_pressed) ||
                  (prev_ended != link.game_ended) ||
                  (prev_score != link.score);
    // Only fires while nothing is queued, so a coincident change yields one frame.
    refresh_hit = (state == IDLE) && !pending &&
                  (refresh_cnt == RW'(REFRESH_CYCLES - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending) state_nxt = START;
      START:   if (baud_end) state_nxt = DATA;
      DATA:    if (baud_end && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    if (baud_end) state_nxt = (byte_idx == 2'd2) ? GAP : START;
      GAP:     if (baud_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      byte_idx    <= '0;
      refresh_cnt <= '0;
      pending     <= 1'b1;
      prev_start  <= 1'b0;
      prev_ended  <= 1'b0;
      prev_score  <= '0;
      b0          <= '0;
      b1          <= '0;
    end else begin
      prev_start <= link.start_pressed;
      prev_ended <= link.game_ended;
      prev_score <= link.score;

      baud_cnt <= (state == IDLE || baud_end) ? '0 : baud_cnt + DW'(1);

      if (state == DATA && baud_end) bit_cnt <= bit_cnt + 3'd1;

      if (frame_start)                  byte_idx <= '0;
      else if (state == STOP && baud_end) byte_idx <= byte_idx + 2'd1;

      if (frame_start)        refresh_cnt <= '0;
      else if (state == IDLE) refresh_cnt <= refresh_cnt + RW'(1);

      // The snapshot consumes pending; anything arriving later queues a follow-up.
      if (change || refresh_hit) pending <= 1'b1;
      else if (frame_start)      pending <= 1'b0;

      if (frame_start) begin
        b0 <= {4'hA, 2'b00, link.game_ended, link.start_pressed};
        b1 <= link.score;
      end
    end
  end

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = b0;
      2'd1:    cur_byte = b1;
      default: cur_byte = b0 ^ b1;
    endcase
    tx_o   = 1'b1;
    busy_o = (state != IDLE);
    sent_o = 1'b0;
    case (state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = cur_byte[bit_cnt];
      GAP:     sent_o = baud_end;
      default: tx_o = 1'b1;
    endcase
  end

  assign link.tx         = tx_o;
  assign link.tx_busy    = busy_o;
  assign link.frame_sent = sent_o;
endmodule
